// File: rtl/game_sequencer.sv
// Game flow sequencer: IDLE/PLAY/RESPAWN/LEVEL_UP/GAME_OVER with lives, BCD level and car speed.
// All outputs registered (one cycle from input sample to output); no backpressure, inputs are sampled every cycle.
module game_sequencer #(
    parameter int RESPAWN_FRAMES = 60,
    parameter int OVER_FRAMES    = 180,
    parameter int MAX_SPEED      = 31
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       restart,
    input  logic       hit,
    input  logic       goal,
    output logic [2:0] state,
    output logic [3:0] lives,
    output logic [3:0] level_tens,
    output logic [3:0] level_units,
    output logic [4:0] speed_car,
    output logic       respawn,
    output logic       freeze,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PLAY      = 3'd1;
    localparam logic [2:0] S_RESPAWN   = 3'd2;
    localparam logic [2:0] S_LEVEL_UP  = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    // Counter sized for the longer timeout, never narrower than 8 bits.
    localparam int MAX_FRAMES = (RESPAWN_FRAMES > OVER_FRAMES) ? RESPAWN_FRAMES : OVER_FRAMES;
    localparam int CW = ($clog2(MAX_FRAMES + 1) < 8) ? 8 : $clog2(MAX_FRAMES + 1);
    localparam logic [CW-1:0] RESPAWN_LAST = CW'(RESPAWN_FRAMES - 1);
    localparam logic [CW-1:0] OVER_LAST    = CW'(OVER_FRAMES - 1);
    localparam logic [4:0]    SPEED_MAX    = 5'(MAX_SPEED);

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [3:0]    r_lives;
    logic [3:0]    w_lives_nxt;
    logic [3:0]    r_tens;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    r_units;
    logic [3:0]    w_units_nxt;
    logic [4:0]    r_speed;
    logic [4:0]    w_speed_nxt;
    logic          r_respawn;
    logic          w_respawn_nxt;
    logic          r_freeze;
    logic          r_game_over;
    logic          w_resp_done;
    logic          w_over_done;

    // The tick that brings the count to the limit is the one that ends the visit.
    assign w_resp_done = frame_tick && (r_count == RESPAWN_LAST);
    assign w_over_done = frame_tick && (r_count == OVER_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (restart) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next_state = S_PLAY;
                end
                S_PLAY: begin
                    if (hit) begin
                        w_next_state = (r_lives == 4'b0001) ? S_GAME_OVER : S_RESPAWN;
                    end else if (goal) begin
                        w_next_state = S_LEVEL_UP;
                    end
                end
                S_RESPAWN: begin
                    if (w_resp_done) w_next_state = S_PLAY;
                end
                S_LEVEL_UP: begin
                    w_next_state = S_PLAY;
                end
                S_GAME_OVER: begin
                    if (w_over_done) w_next_state = S_IDLE;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_count_nxt   = r_count;
        w_lives_nxt   = r_lives;
        w_tens_nxt    = r_tens;
        w_units_nxt   = r_units;
        w_speed_nxt   = r_speed;
        w_respawn_nxt = 1'b0;
        if (restart) begin
            w_count_nxt   = '0;
            w_lives_nxt   = 4'b1111;
            w_tens_nxt    = 4'd0;
            w_units_nxt   = 4'd0;
            w_speed_nxt   = 5'd0;
            w_respawn_nxt = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_respawn_nxt = start;
                end
                S_PLAY: begin
                    if (hit) begin
                        w_lives_nxt = r_lives >> 1;
                        w_count_nxt = '0;
                    end
                end
                S_RESPAWN: begin
                    if (w_resp_done) begin
                        w_count_nxt   = '0;
                        w_respawn_nxt = 1'b1;
                    end else if (frame_tick) begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                S_LEVEL_UP: begin
                    // BCD increment, holding at 99.
                    if (r_units != 4'd9) begin
                        w_units_nxt = r_units + 4'd1;
                    end else if (r_tens != 4'd9) begin
                        w_units_nxt = 4'd0;
                        w_tens_nxt  = r_tens + 4'd1;
                    end
                    if (r_speed < SPEED_MAX) w_speed_nxt = r_speed + 5'd1;
                    w_respawn_nxt = 1'b1;
                end
                S_GAME_OVER: begin
                    if (w_over_done) begin
                        w_count_nxt = '0;
                        w_lives_nxt = 4'b1111;
                        w_tens_nxt  = 4'd0;
                        w_units_nxt = 4'd0;
                        w_speed_nxt = 5'd0;
                    end else if (frame_tick) begin
                        w_count_nxt = r_count + CW'(1);
                    end
                end
                default: begin
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count     <= '0;
            r_lives     <= 4'b1111;
            r_tens      <= 4'd0;
            r_units     <= 4'd0;
            r_speed     <= 5'd0;
            r_respawn   <= 1'b0;
            r_freeze    <= 1'b1;
            r_game_over <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_lives     <= w_lives_nxt;
            r_tens      <= w_tens_nxt;
            r_units     <= w_units_nxt;
            r_speed     <= w_speed_nxt;
            r_respawn   <= w_respawn_nxt;
            r_freeze    <= (w_next_state != S_PLAY);
            r_game_over <= (w_next_state == S_GAME_OVER);
        end
    end

    assign state       = r_state;
    assign lives       = r_lives;
    assign level_tens  = r_tens;
    assign level_units = r_units;
    assign speed_car   = r_speed;
    assign respawn     = r_respawn;
    assign freeze      = r_freeze;
    assign game_over   = r_game_over;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter RESPAWN_FRAMES, default 60: frame ticks spent frozen after a non-fatal hit.
REQ-002 Parameter OVER_FRAMES, default 180: frame ticks spent in GAME_OVER before returning to IDLE.
REQ-003 Parameter MAX_SPEED, default 31: saturation value of speed_car.
REQ-004 Clocking SHALL be one clock, CLK; reset SHALL be asynchronous and active-low, RST_N.
REQ-005 CLK  input  1  system clock, all logic on rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 start  input  1  level-sensitive start request (any movement switch).
REQ-009 restart  input  1  level-sensitive restart request (all four switches pressed).
REQ-010 hit  input  1  one-cycle collision pulse from player/car overlap logic.
REQ-011 goal  input  1  one-cycle pulse when player reaches top row.
REQ-012 state  output  3  current state encoding: IDLE=0, PLAY=1, RESPAWN=2, LEVEL_UP=3, GAME_OVER=4.
REQ-013 lives  output  4  thermometer life count, drives LED1..LED4.
REQ-014 level_tens, level_units  output  4 each  BCD level for seven-segment digits.
REQ-015 speed_car  output  5  car speed step for car movers.
REQ-016 respawn  output  1  one-cycle pulse: player position returns to start cell.
REQ-017 freeze  output  1  high when player movement and cars are halted.
REQ-018 game_over  output  1  high while in GAME_OVER.

Function
REQ-019 All outputs SHALL be registered; no combinational input-to-output path.
REQ-020 IDLE: freeze=1; start=1 -> PLAY next cycle with respawn pulsed that same cycle.
REQ-021 PLAY: freeze=0; hit=1 with lives!=4'b0001 -> lives shifted right by one, -> RESPAWN.
REQ-022 PLAY: hit=1 with lives==4'b0001 -> lives=4'b0000, -> GAME_OVER.
REQ-023 PLAY: goal=1 and hit=0 -> LEVEL_UP; hit and goal in the same cycle -> hit handling only, goal dropped.
REQ-024 RESPAWN: freeze=1; frame counter cleared on entry, incremented per frame_tick; on reaching RESPAWN_FRAMES -> PLAY with respawn pulsed; hit and goal ignored.
REQ-025 LEVEL_UP: lasts exactly one cycle; level incremented in BCD (units 9 -> 0 with tens+1); level 99 saturates; speed_car +1 saturating at MAX_SPEED; respawn pulsed; -> PLAY.
REQ-026 GAME_OVER: freeze=1, game_over=1; counter as REQ-024 with OVER_FRAMES; on expiry -> IDLE with lives=4'b1111, level=00, speed_car=0.
REQ-027 restart=1 in any state SHALL, next cycle, force IDLE, lives=4'b1111, level=00, speed_car=0, counter=0, respawn=1 for one cycle; restart has priority over all other inputs.
REQ-028 start held through GAME_OVER expiry SHALL NOT skip IDLE; IDLE->PLAY requires start sampled in IDLE.
REQ-029 Frame counter SHALL be 8 bits wide minimum and never wrap within one state visit.
REQ-030 Unused state encodings SHALL recover to IDLE on the next cycle.

Reset
REQ-031 RST_N=0 SHALL immediately force state=IDLE, lives=4'b1111, level_tens=0, level_units=0, speed_car=0, respawn=0, freeze=1, game_over=0, counter=0.
REQ-032 RST_N asserted mid-RESPAWN or mid-GAME_OVER SHALL discard the counter; first cycle after release is IDLE.

Verification
REQ-033 Reset release, start=1 one cycle -> state=PLAY next cycle, respawn=1 one cycle, freeze=0.
REQ-034 In PLAY, four hit pulses each followed by 60 frame_ticks -> lives 0111, 0011, 0001, then 0000 with state=GAME_OVER; after 180 ticks state=IDLE, lives=1111.
REQ-035 From level 09, speed 9, goal pulse -> LEVEL_UP one cycle, level_tens=1, level_units=0, speed_car=10, back in PLAY.
REQ-036 Level 99, speed 31, goal -> level stays 99, speed_car stays 31, respawn pulsed.
REQ-037 hit and goal same cycle in PLAY with lives=1111 -> state=RESPAWN, lives=0111, level unchanged.
REQ-038 restart=1 during GAME_OVER tick 50, level 12 -> next cycle IDLE, level 00, speed 0, lives 1111.
